piso_serializer: RTL and testbench

Parallel-in, serial-out shift register: the transmit-side counterpart of the team's `sipo` deserializer. It captures a WIDTH-bit word on a load handshake and shifts it out one bit per enabled clock. The `s_out`/`en` pair drives a `sipo` `s_in`/`en` pair directly, so a `piso_serializer`→`sipo` loopback reproduces the original word. It also frames the word with `busy`/`done` status so upstream logic can stream back-to-back words.

---
 rtl/piso_serializer.sv | 189 ++++++++++++++++++
 tb/tb_piso_serializer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in, serial-out shift register. It captures a WIDTH-bit word on a
// load handshake and shifts it out one bit per enabled clock, framed by
// busy/done status. It is the transmit-side partner of the sipo deserializer:
// s_out/en connect straight to a sipo s_in/en pair.
//
// Optional feature (compile-time macro): PISO_PARITY_EN
//   When this macro is defined, an even-parity bit follows the last data bit,
//   so a frame is WIDTH+1 bits long. When it is undefined, a frame is exactly
//   WIDTH bits.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: p_in[WIDTH-1] is sent first; 0: p_in[0] is sent first
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         shift enable; a frame advances only on edges with en=1
//   load       capture request for p_in; accepted only while ready=1
//   p_in       parallel word to transmit
//   ready      a load will be accepted (always !busy)
//   s_out      serial data bit (registered)
//   busy       frame in progress (registered)
//   done       one-cycle pulse on the edge that ends a frame (registered)
//   state_dbg  current FSM state encoding (0 idle, 1 shift, 2 parity)
//
// Handshake: load/ready follow valid/ready semantics. A word transfers on a
// rising clk edge where load=1 and ready=1. p_in is sampled only on that
// edge, and load is ignored on any edge where ready=0. en has no effect on
// acceptance.
// -----------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] p_in,
    output logic             ready,
    output logic             s_out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    state_t           state_q, state_n;
    logic [WIDTH-1:0] shift_q, shift_n;
    logic [CW-1:0]    cnt_q,   cnt_n;
    logic             s_out_q, s_out_n;
    logic             busy_q,  busy_n;
    logic             done_q,  done_n;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_n;
`endif

    // First bit of a freshly captured word, and the bit that follows the
    // current head of the shift register. The shift register keeps the
    // bit currently on s_out at its head, so the next bit sits one place
    // further in.
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        if (MSB_FIRST != 0) begin
            first_bit = p_in[WIDTH-1];
            next_bit  = shift_q[WIDTH-2];
            shifted   = {shift_q[WIDTH-2:0], 1'b0};
        end else begin
            first_bit = p_in[0];
            next_bit  = shift_q[1];
            shifted   = {1'b0, shift_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_n  = state_q;
        shift_n  = shift_q;
        cnt_n    = cnt_q;
        s_out_n  = s_out_q;
        busy_n   = busy_q;
        done_n   = 1'b0;
`ifdef PISO_PARITY_EN
        parity_n = parity_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                s_out_n = 1'b0;
                busy_n  = 1'b0;
                if (load) begin
                    shift_n  = p_in;
                    s_out_n  = first_bit;
                    cnt_n    = '0;
                    busy_n   = 1'b1;
                    state_n  = ST_SHIFT;
`ifdef PISO_PARITY_EN
                    parity_n = ^p_in;
`endif
                end
            end
            ST_SHIFT: begin
                if (en) begin
                    if (cnt_q != LAST_CNT) begin
                        shift_n = shifted;
                        s_out_n = next_bit;
                        cnt_n   = cnt_q + CW'(1);
                    end else begin
`ifdef PISO_PARITY_EN
                        s_out_n = parity_q;
                        state_n = ST_PARITY;
`else
                        s_out_n = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
`endif
                    end
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                if (en) begin
                    s_out_n = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
`endif
            default: begin
                s_out_n = 1'b0;
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            s_out_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_n;
            shift_q  <= shift_n;
            cnt_q    <= cnt_n;
            s_out_q  <= s_out_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
`ifdef PISO_PARITY_EN
            parity_q <= parity_n;
`endif
        end
    end

    assign s_out     = s_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ready     = !busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Directed bench for piso_serializer. dut0 uses WIDTH=4, MSB_FIRST=1 and dut1
// uses WIDTH=4, MSB_FIRST=0. The two instances share the clock and the reset.
// Every scenario task compares the observed {s_out, busy, done, ready} vector
// against hand-computed values one cycle at a time. The sampling point is #1
// after each rising edge.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, load;
    logic [3:0] p_in;
    logic       ready, s_out, busy, done;
    logic [1:0] state_dbg;
    logic       en1, load1;
    logic [3:0] p_in1;
    logic       ready1, s_out1, busy1, done1;
    logic [1:0] state_dbg1;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut0 (
        .clk(clk), .rst(rst), .en(en), .load(load), .p_in(p_in),
        .ready(ready), .s_out(s_out), .busy(busy), .done(done),
        .state_dbg(state_dbg)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .load(load1), .p_in(p_in1),
        .ready(ready1), .s_out(s_out1), .busy(busy1), .done(done1),
        .state_dbg(state_dbg1)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; p_in = 4'b0000;
        en1 = 1'b0; load1 = 1'b0; p_in1 = 4'b0000;
        repeat (2) tick();
        checks++;
        if ({s_out, busy, done, ready, state_dbg} !== 6'b0001_00) begin
            errors++;
            $display("FAIL reset_held: got %b exp %b",
                     {s_out, busy, done, ready, state_dbg}, 6'b0001_00);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({s_out, busy, done, ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_release: got %b exp %b", {s_out, busy, done, ready}, 4'b0001);
        end
    endtask

    task automatic test_basic();
        logic [3:0] word;
        logic [3:0] got;
        logic [3:0] exp_v;
        word = 4'b1011;
        got  = 4'b0000;
        en = 1'b1; p_in = word; load = 1'b1;
        tick();
        load = 1'b0; p_in = 4'b0100;  // later p_in changes must not matter
        for (int c = 1; c <= 6; c++) begin
            if (c <= 4) exp_v = {word[4-c], 3'b100};
            else if (c == 5) exp_v = 4'b0011;
            else exp_v = 4'b0001;
            checks++;
            if ({s_out, busy, done, ready} !== exp_v) begin
                errors++;
                $display("FAIL basic cycle %0d: got %b exp %b", c, {s_out, busy, done, ready}, exp_v);
            end
            if (c <= 4) got = {got[2:0], s_out};
            tick();
        end
        checks++;
        if (got !== word) begin
            errors++;
            $display("FAIL basic_loopback: got %b exp %b", got, word);
        end
    endtask

    task automatic test_enable_gaps();
        logic s_tab [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic b_tab [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic d_tab [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic e_tab [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] exp_v;
        // A load is accepted even with en low.
        en = 1'b0; p_in = 4'b0110; load = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            exp_v = {s_tab[c-1], b_tab[c-1], d_tab[c-1], !b_tab[c-1]};
            checks++;
            if ({s_out, busy, done, ready} !== exp_v) begin
                errors++;
                $display("FAIL enable_gaps cycle %0d: got %b exp %b", c, {s_out, busy, done, ready}, exp_v);
            end
            en = e_tab[c-1];
            tick();
        end
        en = 1'b1;
    endtask

    task automatic test_load_busy();
        logic [3:0] exp_v;
        int n_done;
        n_done = 0;
        en = 1'b1; p_in = 4'b1011; load = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c <= 4) exp_v = {(c != 2), 3'b100};
            else if (c == 5) exp_v = 4'b0011;
            else exp_v = 4'b0001;
            checks++;
            if ({s_out, busy, done, ready} !== exp_v) begin
                errors++;
                $display("FAIL load_busy cycle %0d: got %b exp %b", c, {s_out, busy, done, ready}, exp_v);
            end
            if (done === 1'b1) n_done++;
            if (c == 2) begin
                load = 1'b1; p_in = 4'b0000;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        checks++;
        if (n_done !== 1) begin
            errors++;
            $display("FAIL load_busy_done_count: got %0d exp %0d", n_done, 1);
        end
    endtask

    task automatic test_back_to_back();
        logic s_tab [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic b_tab [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] exp_v;
        int first_done, second_done;
        first_done = -1; second_done = -1;
        en = 1'b1; p_in = 4'b1001; load = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            exp_v = {s_tab[c-1], b_tab[c-1], (c == 5 || c == 10), !b_tab[c-1]};
            checks++;
            if ({s_out, busy, done, ready} !== exp_v) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %b exp %b", c, {s_out, busy, done, ready}, exp_v);
            end
            if (done === 1'b1) begin
                if (first_done < 0) first_done = c;
                else second_done = c;
            end
            if (c == 5) begin
                load = 1'b1; p_in = 4'b0111;
            end else begin
                load = 1'b0;
            end
            tick();
        end
        checks++;
        if (second_done - first_done !== 5 || first_done < 0 || second_done < 0) begin
            errors++;
            $display("FAIL back_to_back_done_gap: got %0d..%0d exp 5..10", first_done, second_done);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_v;
        en = 1'b1; p_in = 4'b1111; load = 1'b1;
        tick();
        load = 1'b0;
        tick();  // cycle 2: second bit on s_out
        checks++;
        if ({s_out, busy, done, ready} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_mid_pre: got %b exp %b", {s_out, busy, done, ready}, 4'b1100);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({s_out, busy, done, ready, state_dbg} !== 6'b0001_00) begin
            errors++;
            $display("FAIL reset_mid_async: got %b exp %b",
                     {s_out, busy, done, ready, state_dbg}, 6'b0001_00);
        end
        rst = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            tick();
            checks++;
            if ({s_out, busy, done, ready} !== 4'b0001) begin
                errors++;
                $display("FAIL reset_mid_no_done cycle %0d: got %b exp %b", c, {s_out, busy, done, ready}, 4'b0001);
            end
        end
        p_in = 4'b1010; load = 1'b1;
        tick();
        load = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (c <= 4) exp_v = {(c == 1 || c == 3), 3'b100};
            else exp_v = 4'b0011;
            checks++;
            if ({s_out, busy, done, ready} !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_reload cycle %0d: got %b exp %b", c, {s_out, busy, done, ready}, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_lsb_parity();
`ifdef PISO_PARITY_EN
        localparam int NC = 6;
        logic s_tab [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`else
        localparam int NC = 5;
        logic s_tab [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
        logic [3:0] exp_v;
        logic       b;
        en1 = 1'b1; p_in1 = 4'b1011; load1 = 1'b1;
        tick();
        load1 = 1'b0;
        for (int c = 1; c <= NC + 1; c++) begin
            b = (c < NC);
            exp_v = {s_tab[c-1], b, (c == NC), !b};
            checks++;
            if ({s_out1, busy1, done1, ready1} !== exp_v) begin
                errors++;
                $display("FAIL lsb_parity cycle %0d: got %b exp %b", c, {s_out1, busy1, done1, ready1}, exp_v);
            end
            tick();
        end
        en1 = 1'b0;
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        test_reset();
        test_basic();
        test_enable_gaps();
        test_load_busy();
        test_back_to_back();
        test_reset_mid();
        test_lsb_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends on its own.
    initial begin
        #50000;
        $display("FAIL timeout: got no finish exp finish before 50000");
        $fatal(1, "timeout");
    end

endmodule
